// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter that grants one of NREQ requesters burst write access to a shared WIDTH-bit register.
// Optional macro ARB_LOCK_EN adds a lock input that holds the grant past MAX_BURST.
module dff_bank_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   d_in,
`ifdef ARB_LOCK_EN
    input  logic                    lock,
`endif
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic [2:0]              owner,
    output logic [WIDTH-1:0]        q,
    output logic [WIDTH-1:0]        qbar
);

    localparam int          IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0]  MAX_CNT = 4'(MAX_BURST);

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    // Handshake: req[i] is both request and write-valid; a write happens on
    // every edge where gnt[i] is set and req[i] is high.

    state_t             state, state_n;
    logic [NREQ-1:0]    gnt_n;
    logic [IW-1:0]      owner_r, owner_n;
    logic [IW-1:0]      last_owner, last_owner_n;
    logic [3:0]         count, count_n;
    logic [WIDTH-1:0]   q_n;
    logic [WIDTH-1:0]   slice [NREQ];
    logic [IW-1:0]      cand;
    logic [IW-1:0]      winner;
    logic               found;
    logic               hold;

`ifdef ARB_LOCK_EN
    assign hold = lock;
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            slice[i] = d_in[i*WIDTH +: WIDTH];
        end
    end

    // Search starts just above the last owner so it lands at lowest priority.
    always_comb begin
        winner = last_owner;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_owner) + k) % NREQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_n      = state;
        gnt_n        = gnt;
        owner_n      = owner_r;
        last_owner_n = last_owner;
        count_n      = count;
        q_n          = q;
        case (state)
            IDLE: begin
                gnt_n = '0;
                if (found) begin
                    gnt_n[winner] = 1'b1;
                    owner_n       = winner;
                    count_n       = 4'd0;
                    state_n       = OWN;
                end
            end
            OWN: begin
                if (req[owner_r]) begin
                    q_n = slice[owner_r];
                    if ((count + 4'd1) >= MAX_CNT) begin
                        count_n = MAX_CNT;
                        if (!hold) begin
                            gnt_n        = '0;
                            last_owner_n = owner_r;
                            state_n      = IDLE;
                        end
                    end else begin
                        count_n = count + 4'd1;
                    end
                end else begin
                    gnt_n        = '0;
                    last_owner_n = owner_r;
                    state_n      = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state      <= IDLE;
            gnt        <= '0;
            owner_r    <= '0;
            last_owner <= IW'(NREQ - 1);
            count      <= 4'd0;
            q          <= '0;
        end else begin
            state      <= state_n;
            gnt        <= gnt_n;
            owner_r    <= owner_n;
            last_owner <= last_owner_n;
            count      <= count_n;
            q          <= q_n;
        end
    end

    // qbar is derived from q so the pair can never disagree.
    assign qbar  = ~q;
    assign busy  = |gnt;
    assign owner = 3'(owner_r);

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed self-checking bench for dff_bank_arbiter (NREQ=4, WIDTH=8, MAX_BURST=4).
// Lock scenario runs only when ARB_LOCK_EN is defined.
module tb_dff_bank_arbiter;

    logic        clk = 1'b0;
    logic        clear;
    logic [3:0]  req;
    logic [31:0] d_in;
`ifdef ARB_LOCK_EN
    logic        lock;
`endif
    logic [3:0]  gnt;
    logic        busy;
    logic [2:0]  owner;
    logic [7:0]  q;
    logic [7:0]  qbar;

    int asserts  = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dff_bank_arbiter #(.NREQ(4), .WIDTH(8), .MAX_BURST(4)) dut (
        .clk   (clk),
        .clear (clear),
        .req   (req),
        .d_in  (d_in),
`ifdef ARB_LOCK_EN
        .lock  (lock),
`endif
        .gnt   (gnt),
        .busy  (busy),
        .owner (owner),
        .q     (q),
        .qbar  (qbar)
    );

    // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        req   = 4'b0000;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        req   = 4'hF;
        d_in  = 32'h5A5A_5A5A;
        clear = 1'b1;
        tick();
        tick();
        asserts++; if (q !== 8'h00) begin failures++; $display("FAIL reset_q: got %h expected 00", q); end
        asserts++; if (qbar !== 8'hFF) begin failures++; $display("FAIL reset_qbar: got %h expected ff", qbar); end
        asserts++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        asserts++; if (owner !== 3'd0) begin failures++; $display("FAIL reset_owner: got %0d expected 0", owner); end
        req   = 4'b0000;
        clear = 1'b0;
        tick();
    endtask

    task automatic test_single_burst();
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        req = 4'b0100;
        d_in[23:16] = vals[0];
        tick();
        asserts++; if (gnt !== 4'b0100) begin failures++; $display("FAIL burst_grant: gnt=%b expected 0100", gnt); end
        asserts++; if (owner !== 3'd2) begin failures++; $display("FAIL burst_owner: got %0d expected 2", owner); end
        asserts++; if (q !== 8'h00) begin failures++; $display("FAIL burst_no_write_on_grant: q=%h expected 00", q); end
        for (int i = 0; i < 4; i++) begin
            d_in[23:16] = vals[i];
            tick();
            asserts++; if (q !== vals[i]) begin failures++; $display("FAIL burst_q[%0d]: got %h expected %h", i, q, vals[i]); end
            asserts++; if (qbar !== ~vals[i]) begin failures++; $display("FAIL burst_qbar[%0d]: got %h expected %h", i, qbar, ~vals[i]); end
            if (i < 3) begin
                asserts++; if (gnt !== 4'b0100) begin failures++; $display("FAIL burst_hold[%0d]: gnt=%b expected 0100", i, gnt); end
            end
        end
        asserts++; if (gnt !== 4'b0000) begin failures++; $display("FAIL burst_release: gnt=%b expected 0000", gnt); end
        asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL burst_release_busy: got %b expected 0", busy); end
        asserts++; if (owner !== 3'd2) begin failures++; $display("FAIL burst_owner_hold: got %0d expected 2", owner); end
        d_in[23:16] = 8'h55;
        tick();
        asserts++; if (q !== 8'h44) begin failures++; $display("FAIL burst_bubble_q: got %h expected 44", q); end
        asserts++; if (gnt !== 4'b0100) begin failures++; $display("FAIL burst_regrant: gnt=%b expected 0100", gnt); end
        req = 4'b0000;
        tick();
        asserts++; if (gnt !== 4'b0000) begin failures++; $display("FAIL burst_drop: gnt=%b expected 0000", gnt); end
        asserts++; if (q !== 8'h44) begin failures++; $display("FAIL burst_drop_q: got %h expected 44", q); end
    endtask

    task automatic test_round_robin();
        int         order [5];
        logic [7:0] vals  [4];
        logic [3:0] exp_gnt;
        order[0] = 0; order[1] = 1; order[2] = 3; order[3] = 0; order[4] = 1;
        vals[0] = 8'h0A; vals[1] = 8'h1B; vals[2] = 8'h2C; vals[3] = 8'h3D;
        pulse_clear();
        d_in = {vals[3], vals[2], vals[1], vals[0]};
        req  = 4'b1011;
        for (int g = 0; g < 5; g++) begin
            tick();
            exp_gnt = 4'b0001 << order[g];
            asserts++; if (gnt !== exp_gnt) begin failures++; $display("FAIL rr_gnt[%0d]: got %b expected %b", g, gnt, exp_gnt); end
            asserts++; if (owner !== 3'(order[g])) begin failures++; $display("FAIL rr_owner[%0d]: got %0d expected %0d", g, owner, order[g]); end
            for (int w = 0; w < 4; w++) begin
                tick();
                asserts++; if (q !== vals[order[g]]) begin failures++; $display("FAIL rr_q[%0d.%0d]: got %h expected %h", g, w, q, vals[order[g]]); end
            end
            asserts++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rr_bubble[%0d]: gnt=%b expected 0000", g, gnt); end
        end
        pulse_clear();
    endtask

    task automatic test_early_release_and_clear();
        req = 4'b1010;
        d_in = 32'h0000_0000;
        tick();
        asserts++; if (gnt !== 4'b0010) begin failures++; $display("FAIL er_gnt: got %b expected 0010", gnt); end
        d_in[15:8] = 8'h61;
        tick();
        asserts++; if (q !== 8'h61) begin failures++; $display("FAIL er_q1: got %h expected 61", q); end
        d_in[15:8] = 8'h62;
        tick();
        asserts++; if (q !== 8'h62) begin failures++; $display("FAIL er_q2: got %h expected 62", q); end
        req = 4'b1000;
        d_in[15:8] = 8'h63;
        tick();
        asserts++; if (gnt !== 4'b0000) begin failures++; $display("FAIL er_release: gnt=%b expected 0000", gnt); end
        asserts++; if (q !== 8'h62) begin failures++; $display("FAIL er_hold_q: got %h expected 62", q); end
        tick();
        asserts++; if (gnt !== 4'b1000) begin failures++; $display("FAIL er_next: gnt=%b expected 1000", gnt); end
        asserts++; if (owner !== 3'd3) begin failures++; $display("FAIL er_next_owner: got %0d expected 3", owner); end
        // Clear lands on owner 3's second write edge.
        d_in[31:24] = 8'h77;
        tick();
        asserts++; if (q !== 8'h77) begin failures++; $display("FAIL cl_first_write: got %h expected 77", q); end
        d_in[31:24] = 8'hA5;
        clear = 1'b1;
        tick();
        asserts++; if (q !== 8'h00) begin failures++; $display("FAIL cl_q: got %h expected 00", q); end
        asserts++; if (qbar !== 8'hFF) begin failures++; $display("FAIL cl_qbar: got %h expected ff", qbar); end
        asserts++; if (gnt !== 4'b0000) begin failures++; $display("FAIL cl_gnt: got %b expected 0000", gnt); end
        asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL cl_busy: got %b expected 0", busy); end
        clear = 1'b0;
        req   = 4'b1001;
        tick();
        asserts++; if (gnt !== 4'b0001) begin failures++; $display("FAIL cl_regrant: gnt=%b expected 0001", gnt); end
        asserts++; if (owner !== 3'd0) begin failures++; $display("FAIL cl_regrant_owner: got %0d expected 0", owner); end
        pulse_clear();
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        logic [7:0] v;
        lock = 1'b1;
        req  = 4'b0011;
        d_in = 32'h0000_0000;
        tick();
        asserts++; if (gnt !== 4'b0001) begin failures++; $display("FAIL lock_gnt: got %b expected 0001", gnt); end
        for (int w = 0; w < 7; w++) begin
            v = 8'h80 + 8'(w);
            d_in[7:0] = v;
            tick();
            asserts++; if (q !== v) begin failures++; $display("FAIL lock_q[%0d]: got %h expected %h", w, q, v); end
            asserts++; if (gnt !== 4'b0001) begin failures++; $display("FAIL lock_hold[%0d]: gnt=%b expected 0001", w, gnt); end
        end
        lock = 1'b0;
        d_in[7:0] = 8'hEE;
        tick();
        asserts++; if (q !== 8'hEE) begin failures++; $display("FAIL lock_last_q: got %h expected ee", q); end
        asserts++; if (gnt !== 4'b0000) begin failures++; $display("FAIL lock_release: gnt=%b expected 0000", gnt); end
        pulse_clear();
    endtask
`endif

    initial begin
        clear = 1'b1;
        req   = 4'b0000;
        d_in  = '0;
`ifdef ARB_LOCK_EN
        lock  = 1'b0;
`endif
        test_reset();
        test_single_burst();
        test_round_robin();
        test_early_release_and_clear();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin arbiter and sequencer for one shared WIDTH-bit D-flip-flop register with q/qbar outputs.
- NREQ requesters compete for write ownership. The winner streams data into the register for up to MAX_BURST cycles, then releases it.
- Sits between requesting blocks and the shared storage, replacing ad-hoc direct flop writes.

Parameters:
- NREQ, 4: number of requesters (2..8).
- WIDTH, 8: register data width.
- MAX_BURST, 4: maximum writes per grant (1..15).

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  synchronous active-high reset, sampled on posedge clk.
- req  input  NREQ  per-requester request/write-valid, level.
- d_in  input  NREQ*WIDTH  flattened data; slice i = d_in[i*WIDTH +: WIDTH].
- gnt  output  NREQ  registered one-hot grant.
- busy  output  1  high while any gnt bit is set.
- owner  output  3  binary index of the current/last owner.
- q  output  WIDTH  shared register value.
- qbar  output  WIDTH  bitwise complement of q, always consistent with q.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: clk plus clear, clear sampled on the rising edge of clk; no asynchronous paths.
- Reset values on an edge with clear=1:
  - q=0, qbar=all ones, gnt=0, busy=0, owner=0.
  - Internal last_owner=NREQ-1, so requester 0 has first priority. Burst count=0. State=IDLE.
- clear has priority over every other event, including a write in the same edge. Clear mid-burst aborts the burst; no write occurs on that edge.
- States:
  - IDLE: gnt=0.
  - OWN: exactly one gnt bit set.
- IDLE transitions:
  - Any req bit high at an edge → pick the first set bit searching last_owner+1, last_owner+2, … mod NREQ.
  - Set gnt[winner]; owner=winner; count=0; go to OWN.
  - No write on the grant edge. Latency: req sampled at edge k → gnt visible after edge k; first write at edge k+1.
  - All req low → stay in IDLE.
- OWN, per edge, with i = owner:
  - req[i]=1: q<=d_in slice i, qbar<=~slice i, count<=count+1. If count+1==MAX_BURST, clear gnt, set last_owner=i, go to IDLE.
  - req[i]=0: no write, clear gnt, last_owner=i, go to IDLE. A requester dropping req is an early release.
  - Other requesters' req bits and data are ignored while OWN.
- Release bubble: every release is followed by one IDLE cycle with gnt=0, so the minimum spacing between grants is one cycle.
- A requester that hit MAX_BURST and still holds req re-enters arbitration at lowest priority. It regains the grant only if no other req is set.
- busy equals |gnt. owner holds its value through IDLE.
- q/qbar hold their value whenever no write occurs. There is never a cycle where qbar != ~q.
- Count width is 4 bits. MAX_BURST=1 gives single-write grants.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - Adds input port `lock` (1 bit), placed after d_in.
  - In OWN, if lock=1 at the edge where count+1==MAX_BURST, the grant is not released. The write still happens and count saturates at MAX_BURST.
  - Release then occurs only when req[owner]=0 or lock=0 at a write edge with count at MAX_BURST.
  - lock is ignored in IDLE.
- Not defined: no lock port; MAX_BURST is always enforced.

Test Plan (NREQ=4, WIDTH=8, MAX_BURST=4):
1. Reset: hold clear for 2 edges with req=4'hF → q=8'h00, qbar=8'hFF, gnt=0, busy=0, owner=0.
2. Single grant and burst:
   - Stimulus: req=4'b0100 continuously, slice2 = 8'h11, 8'h22, 8'h33, 8'h44, 8'h55 on successive write edges.
   - Response: gnt=4'b0100 one cycle after request; q sequence = 11, 22, 33, 44 with qbar = EE, DD, CC, BB.
   - Then gnt=0 for one cycle and 8'h55 is not written. gnt=4'b0100 again one cycle later (sole requester).
3. Round-robin:
   - Stimulus: req=4'b1011 held, each requester drives a distinct constant.
   - Response: grant order 0, 1, 3, 0, 1, … Each grant gives 4 writes followed by one gnt=0 bubble.
4. Early release: owner 1 drops req after 2 writes → gnt clears on that edge, q keeps the second value, next grant goes to the next pending requester above 1.
5. Clear mid-burst: assert clear at owner 3's second write edge with slice3=8'hA5 → q=8'h00, qbar=8'hFF, gnt=0. After clear drops, requester 0 wins first.
6. ARB_LOCK_EN: owner 0 with lock=1 performs 7 consecutive writes with no release. Dropping lock → gnt clears at the next write edge.
